// File: rtl/calc_op_ctrl_pkg.sv
// Shared types and constants for the calculator operation controller.
// Latency: none (declarations only).
// Backpressure: not applicable.
package calc_pkg;

  localparam int RES_W  = 33;
  localparam int OPND_W = 16;

  // Operator codes as delivered by the parser
  localparam logic [4:0] OP_ADD = 5'd0;
  localparam logic [4:0] OP_SUB = 5'd1;
  localparam logic [4:0] OP_MUL = 5'd2;
  localparam logic [4:0] OP_DIV = 5'd3;
  localparam logic [4:0] OP_MOD = 5'd4;

  // Data type codes; anything other than DT_SIGNED behaves as unsigned
  localparam logic [3:0] DT_UNSIGNED = 4'h0;
  localparam logic [3:0] DT_SIGNED   = 4'h1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DISPATCH,
    ST_WAIT_MUL,
    ST_WAIT_DIV,
    ST_DONE
  } state_e;

  // Widen a 16-bit operand to the result width, sign- or zero-extending
  function automatic logic [RES_W-1:0] ext_opnd(input logic [OPND_W-1:0] v, input logic sgn);
    return sgn ? {{(RES_W-OPND_W){v[OPND_W-1]}}, v} : {{(RES_W-OPND_W){1'b0}}, v};
  endfunction

endpackage

// File: rtl/calc_op_ctrl_if.sv
// Bundle of parser, arithmetic-unit and formatter signals around the controller.
// Latency: none (wiring only).
// Backpressure: parser is held off by ctrl_ready; units answer with done.
interface calc_op_ctrl_if;
  import calc_pkg::*;

  // parser side
  logic                parser_done;
  logic [3:0]          dtype;
  logic [4:0]          operator;
  logic [OPND_W-1:0]   src1;
  logic [OPND_W-1:0]   src2;
  logic                ctrl_ready;
  // multiplier side
  logic                mul_start;
  logic [OPND_W-1:0]   mul_src1;
  logic [OPND_W-1:0]   mul_src2;
  logic [RES_W-1:0]    mul_res;
  logic                mul_done;
  // divider side
  logic                div_start;
  logic [OPND_W-1:0]   div_src1;
  logic [OPND_W-1:0]   div_src2;
  logic [OPND_W-1:0]   div_quot;
  logic [OPND_W-1:0]   div_rem;
  logic                div_done;
  // response side
  logic [RES_W-1:0]    calc_res;
  logic                alu_err;
  logic                alu_done;

  // controller view
  modport master (
    input  parser_done, dtype, operator, src1, src2,
    input  mul_res, mul_done, div_quot, div_rem, div_done,
    output ctrl_ready, mul_start, mul_src1, mul_src2,
    output div_start, div_src1, div_src2, calc_res, alu_err, alu_done
  );

  // environment view (parser, units, formatter)
  modport slave (
    output parser_done, dtype, operator, src1, src2,
    output mul_res, mul_done, div_quot, div_rem, div_done,
    input  ctrl_ready, mul_start, mul_src1, mul_src2,
    input  div_start, div_src1, div_src2, calc_res, alu_err, alu_done
  );

endinterface

// File: rtl/calc_op_ctrl_addsub.sv
// 33-bit adder/subtractor with per-dtype operand extension.
// Latency: combinational.
// Backpressure: none.
module calc_addsub
  import calc_pkg::*;
(
  input  logic [3:0]        dtype_i,
  input  logic              sub_i,
  input  logic [OPND_W-1:0] src1_i,
  input  logic [OPND_W-1:0] src2_i,
  output logic [RES_W-1:0]  res_o
);

  logic             sgn;
  logic [RES_W-1:0] a_ext;
  logic [RES_W-1:0] b_ext;

  assign sgn   = (dtype_i == DT_SIGNED);
  assign a_ext = ext_opnd(src1_i, sgn);
  assign b_ext = ext_opnd(src2_i, sgn);
  assign res_o = sub_i ? (a_ext - b_ext) : (a_ext + b_ext);

endmodule

// File: rtl/calc_op_ctrl.sv
// Operation controller: add/sub locally, sequences multiplier and divider.
// Latency: 2 cycles for add/sub/errors; unit latency + 2 for mul/div.
// Backpressure: one op in flight; ctrl_ready low until alu_done retires it.
module calc_op_ctrl
  import calc_pkg::*;
#(
  parameter int TIMEOUT_CYC = 64
) (
  input  logic           clk,
  input  logic           n_rst,
  calc_op_ctrl_if.master bus
);

  localparam int               CNT_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  state_e            state_q;
  logic [3:0]        dtype_q;
  logic [4:0]        op_q;
  logic [OPND_W-1:0] src1_q;
  logic [OPND_W-1:0] src2_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              ctrl_ready_q;
  logic              mul_start_q;
  logic              div_start_q;
  logic [RES_W-1:0]  res_q;
  logic              err_q;
  logic              alu_done_q;
  logic [RES_W-1:0]  addsub_res;

  calc_addsub u_addsub (
    .dtype_i (dtype_q),
    .sub_i   (op_q == OP_SUB),
    .src1_i  (src1_q),
    .src2_i  (src2_q),
    .res_o   (addsub_res)
  );

  // The latched operands feed both units; they only change on acceptance
  assign bus.ctrl_ready = ctrl_ready_q;
  assign bus.mul_start  = mul_start_q;
  assign bus.mul_src1   = src1_q;
  assign bus.mul_src2   = src2_q;
  assign bus.div_start  = div_start_q;
  assign bus.div_src1   = src1_q;
  assign bus.div_src2   = src2_q;
  assign bus.calc_res   = res_q;
  assign bus.alu_err    = err_q;
  assign bus.alu_done   = alu_done_q;

  // Control FSM; start pulses are decided at acceptance so they land in DISPATCH
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q      <= ST_IDLE;
      dtype_q      <= '0;
      op_q         <= '0;
      src1_q       <= '0;
      src2_q       <= '0;
      cnt_q        <= '0;
      ctrl_ready_q <= 1'b0;
      mul_start_q  <= 1'b0;
      div_start_q  <= 1'b0;
      res_q        <= '0;
      err_q        <= 1'b0;
      alu_done_q   <= 1'b0;
    end else begin
      mul_start_q <= 1'b0;
      div_start_q <= 1'b0;
      alu_done_q  <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (ctrl_ready_q && bus.parser_done) begin
            dtype_q      <= bus.dtype;
            op_q         <= bus.operator;
            src1_q       <= bus.src1;
            src2_q       <= bus.src2;
            ctrl_ready_q <= 1'b0;
            mul_start_q  <= (bus.operator == OP_MUL);
            div_start_q  <= ((bus.operator == OP_DIV) || (bus.operator == OP_MOD)) &&
                            (bus.src2 != '0);
            state_q      <= ST_DISPATCH;
          end else begin
            ctrl_ready_q <= 1'b1;
          end
        end
        ST_DISPATCH: begin
          cnt_q <= '0;
          case (op_q)
            OP_ADD, OP_SUB: begin
              res_q      <= addsub_res;
              err_q      <= 1'b0;
              alu_done_q <= 1'b1;
              state_q    <= ST_DONE;
            end
            OP_MUL: state_q <= ST_WAIT_MUL;
            OP_DIV, OP_MOD: begin
              if (src2_q != '0) begin
                state_q <= ST_WAIT_DIV;
              end else begin
                res_q      <= '0;
                err_q      <= 1'b1;
                alu_done_q <= 1'b1;
                state_q    <= ST_DONE;
              end
            end
            default: begin
              res_q      <= '0;
              err_q      <= 1'b1;
              alu_done_q <= 1'b1;
              state_q    <= ST_DONE;
            end
          endcase
        end
        ST_WAIT_MUL: begin
          if (bus.mul_done) begin
            res_q      <= bus.mul_res;
            err_q      <= 1'b0;
            alu_done_q <= 1'b1;
            state_q    <= ST_DONE;
          end else if (cnt_q == CNT_LAST) begin
            res_q      <= '0;
            err_q      <= 1'b1;
            alu_done_q <= 1'b1;
            state_q    <= ST_DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_WAIT_DIV: begin
          if (bus.div_done) begin
            res_q      <= {{(RES_W-OPND_W){1'b0}},
                           (op_q == OP_MOD) ? bus.div_rem : bus.div_quot};
            err_q      <= 1'b0;
            alu_done_q <= 1'b1;
            state_q    <= ST_DONE;
          end else if (cnt_q == CNT_LAST) begin
            res_q      <= '0;
            err_q      <= 1'b1;
            alu_done_q <= 1'b1;
            state_q    <= ST_DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_DONE: begin
          ctrl_ready_q <= 1'b1;
          state_q      <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_calc_op_ctrl.sv
// Directed bench for calc_op_ctrl with stub multiplier and divider.
// Latency: checked per vector against hand-computed cycle counts.
// Backpressure: waits on ctrl_ready before each operation.
module tb_calc_op_ctrl;
  import calc_pkg::*;

  localparam int TO = 64;

  logic clk = 1'b0;
  logic n_rst;
  always #5 clk = ~clk;

  calc_op_ctrl_if bus();

  calc_op_ctrl #(.TIMEOUT_CYC(TO)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input logic [32:0] act, input logic [32:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- stub arithmetic units ----------------
  logic        stub_mul_done = 1'b0, inj_mul_done = 1'b0;
  logic        stub_div_done = 1'b0, inj_div_done = 1'b0;
  logic [32:0] stub_mul_res  = '0;
  logic [15:0] stub_quot = '0, stub_rem = '0;
  int          mul_lat = 1, div_lat = 1;
  bit          mul_en = 1'b1, div_en = 1'b1;
  int          mul_starts = 0, div_starts = 0, mul_bad = 0, div_bad = 0;

  assign bus.mul_done = stub_mul_done | inj_mul_done;
  assign bus.mul_res  = stub_mul_res;
  assign bus.div_done = stub_div_done | inj_div_done;
  assign bus.div_quot = stub_quot;
  assign bus.div_rem  = stub_rem;

  int          mul_cnt = 0;
  bit          mul_busy = 1'b0;
  logic [15:0] mul_a = '0, mul_b = '0;

  // Multiplier stub: done pulse mul_lat cycles after the start, operands watched
  always @(negedge clk) begin
    stub_mul_done = 1'b0;
    if (!n_rst) begin
      mul_busy = 1'b0;
    end else begin
      if (mul_busy) begin
        if (bus.mul_src1 !== mul_a || bus.mul_src2 !== mul_b) mul_bad++;
        mul_cnt--;
        if (mul_cnt == 0) begin
          stub_mul_done = 1'b1;
          stub_mul_res  = {1'b0, 32'(mul_a) * 32'(mul_b)};
          mul_busy      = 1'b0;
        end
      end
      if (bus.mul_start === 1'b1) begin
        mul_starts++;
        if (mul_en) begin
          mul_busy = 1'b1;
          mul_cnt  = mul_lat;
          mul_a    = bus.mul_src1;
          mul_b    = bus.mul_src2;
        end
      end
    end
  end

  int          div_cnt = 0;
  bit          div_busy = 1'b0;
  logic [15:0] div_a = '0, div_b = '1;

  // Divider stub: same protocol as the multiplier stub
  always @(negedge clk) begin
    stub_div_done = 1'b0;
    if (!n_rst) begin
      div_busy = 1'b0;
    end else begin
      if (div_busy) begin
        if (bus.div_src1 !== div_a || bus.div_src2 !== div_b) div_bad++;
        div_cnt--;
        if (div_cnt == 0) begin
          stub_div_done = 1'b1;
          stub_quot     = div_a / div_b;
          stub_rem      = div_a % div_b;
          div_busy      = 1'b0;
        end
      end
      if (bus.div_start === 1'b1) begin
        div_starts++;
        if (div_en) begin
          div_busy = 1'b1;
          div_cnt  = div_lat;
          div_a    = bus.div_src1;
          div_b    = bus.div_src2;
        end
      end
    end
  end

  // ---------------- vector table ----------------
  typedef struct {
    string       name;
    logic [3:0]  dt;
    logic [4:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    int          ulat;   // stub unit latency
    bit          uen;    // stub unit answers at all
    int          inj;    // cycle index for a stray mul_done, 0 = none
    logic [32:0] res;
    logic        err;
    int          nmul;
    int          ndiv;
    int          lat;    // cycles from parser_done to alu_done
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input string n, input logic [3:0] dt, input logic [4:0] op,
                              input logic [15:0] a, input logic [15:0] b, input int ulat,
                              input bit uen, input int inj, input logic [32:0] res,
                              input logic err, input int nmul, input int ndiv, input int lat);
    vec_t v;
    v.name = n; v.dt = dt; v.op = op; v.a = a; v.b = b; v.ulat = ulat; v.uen = uen;
    v.inj = inj; v.res = res; v.err = err; v.nmul = nmul; v.ndiv = ndiv; v.lat = lat;
    return v;
  endfunction

  task automatic wait_ready(input string name);
    int w = 0;
    while (bus.ctrl_ready !== 1'b1 && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk({name, "_ready"}, bus.ctrl_ready, 1'b1);
  endtask

  task automatic run_op(input vec_t v);
    int lat, m0, d0, mb0, db0;
    mul_lat = v.ulat; div_lat = v.ulat; mul_en = v.uen; div_en = v.uen;
    m0 = mul_starts; d0 = div_starts; mb0 = mul_bad; db0 = div_bad;
    wait_ready(v.name);
    bus.dtype = v.dt; bus.operator = v.op; bus.src1 = v.a; bus.src2 = v.b;
    bus.parser_done = 1'b1;
    @(negedge clk);
    bus.parser_done = 1'b0;
    lat = 1;
    chk({v.name, "_busy"}, bus.ctrl_ready, 1'b0);
    while (bus.alu_done !== 1'b1 && lat < 200) begin
      inj_mul_done = (v.inj != 0 && lat == v.inj);
      @(negedge clk);
      lat++;
    end
    inj_mul_done = 1'b0;
    chk({v.name, "_done"}, bus.alu_done, 1'b1);
    chk({v.name, "_lat"}, 33'(lat), 33'(v.lat));
    chk({v.name, "_res"}, bus.calc_res, v.res);
    chk({v.name, "_err"}, bus.alu_err, v.err);
    chk({v.name, "_mul_starts"}, 33'(mul_starts - m0), 33'(v.nmul));
    chk({v.name, "_div_starts"}, 33'(div_starts - d0), 33'(v.ndiv));
    chk({v.name, "_opnd_stable"}, 33'((mul_bad - mb0) + (div_bad - db0)), 33'd0);
    @(negedge clk);
    chk({v.name, "_pulse"}, bus.alu_done, 1'b0);
    chk({v.name, "_ready_again"}, bus.ctrl_ready, 1'b1);
    chk({v.name, "_res_held"}, bus.calc_res, v.res);
  endtask

  task automatic check_all_zero(input string name);
    chk({name, "_ready"},  bus.ctrl_ready, 1'b0);
    chk({name, "_mstart"}, bus.mul_start, 1'b0);
    chk({name, "_msrc1"},  33'(bus.mul_src1), 33'd0);
    chk({name, "_msrc2"},  33'(bus.mul_src2), 33'd0);
    chk({name, "_dstart"}, bus.div_start, 1'b0);
    chk({name, "_dsrc1"},  33'(bus.div_src1), 33'd0);
    chk({name, "_res"},    bus.calc_res, 33'd0);
    chk({name, "_err"},    bus.alu_err, 1'b0);
    chk({name, "_done"},   bus.alu_done, 1'b0);
  endtask

  // Counts alu_done pulses over a window of cycles
  task automatic count_done(input int cycles, output int cnt);
    cnt = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (bus.alu_done === 1'b1) cnt++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    vq.push_back(mk("mul_u",      4'h0, OP_MUL, 16'h0009, 16'h0002, 16, 1, 0, 33'h12,        1'b0, 1, 0, 18));
    vq.push_back(mk("add_u",      4'h0, OP_ADD, 16'hFFFF, 16'h0001,  1, 1, 0, 33'h10000,     1'b0, 0, 0, 2));
    vq.push_back(mk("add_s",      4'h1, OP_ADD, 16'hFFFF, 16'h0001,  1, 1, 0, 33'h0,         1'b0, 0, 0, 2));
    vq.push_back(mk("add_s_neg",  4'h1, OP_ADD, 16'h8000, 16'h8000,  1, 1, 0, 33'h1FFFF0000, 1'b0, 0, 0, 2));
    vq.push_back(mk("add_dt7",    4'h7, OP_ADD, 16'hFFFF, 16'hFFFF,  1, 1, 0, 33'h1FFFE,     1'b0, 0, 0, 2));
    vq.push_back(mk("sub_s",      4'h1, OP_SUB, 16'h0002, 16'h0009,  1, 1, 0, 33'h1FFFFFFF9, 1'b0, 0, 0, 2));
    vq.push_back(mk("sub_u",      4'h0, OP_SUB, 16'h0009, 16'h0002,  1, 1, 0, 33'h7,         1'b0, 0, 0, 2));
    vq.push_back(mk("div",        4'h0, OP_DIV, 16'h0009, 16'h0002,  4, 1, 2, 33'h4,         1'b0, 0, 1, 6));
    vq.push_back(mk("mod",        4'h0, OP_MOD, 16'h0009, 16'h0002,  4, 1, 0, 33'h1,         1'b0, 0, 1, 6));
    vq.push_back(mk("div_by0",    4'h0, OP_DIV, 16'h0009, 16'h0000,  4, 1, 0, 33'h0,         1'b1, 0, 0, 2));
    vq.push_back(mk("mod_by0",    4'h0, OP_MOD, 16'h0009, 16'h0000,  4, 1, 0, 33'h0,         1'b1, 0, 0, 2));
    vq.push_back(mk("mul_max",    4'h0, OP_MUL, 16'hFFFF, 16'hFFFF,  1, 1, 0, 33'hFFFE0001,  1'b0, 1, 0, 3));
    vq.push_back(mk("illegal5",   4'h0, 5'd5,   16'h0009, 16'h0002,  1, 1, 0, 33'h0,         1'b1, 0, 0, 2));
    vq.push_back(mk("illegal31",  4'h7, 5'd31,  16'h1234, 16'h5678,  1, 1, 0, 33'h0,         1'b1, 0, 0, 2));
    vq.push_back(mk("mul_timeout",4'h0, OP_MUL, 16'h0009, 16'h0002, 16, 0, 0, 33'h0,         1'b1, 1, 0, TO + 2));

    // reset state
    n_rst = 1'b0;
    bus.parser_done = 1'b0; bus.dtype = '0; bus.operator = '0; bus.src1 = '0; bus.src2 = '0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    n_rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_ready_after", bus.ctrl_ready, 1'b1);

    foreach (vq[i]) run_op(vq[i]);

    // late mul_done after the timeout must be ignored
    inj_mul_done = 1'b1;
    @(negedge clk);
    inj_mul_done = 1'b0;
    count_done(6, cnt);
    chk("late_done_ignored", 33'(cnt), 33'd0);
    chk("late_done_err_held", bus.alu_err, 1'b1);
    chk("late_done_ready", bus.ctrl_ready, 1'b1);

    // second parser_done while busy is ignored, exactly one alu_done
    mul_lat = 10; mul_en = 1'b1;
    cnt = mul_starts;
    wait_ready("busy");
    bus.dtype = 4'h0; bus.operator = OP_MUL; bus.src1 = 16'h0003; bus.src2 = 16'h0005;
    bus.parser_done = 1'b1;
    @(negedge clk);
    bus.operator = OP_ADD; bus.src1 = 16'h1111; bus.src2 = 16'h2222;
    repeat (5) @(negedge clk);
    bus.parser_done = 1'b0;
    chk("busy_mul_starts", 33'(mul_starts - cnt), 33'd1);
    count_done(30, cnt);
    chk("busy_one_done", 33'(cnt), 33'd1);
    chk("busy_res", bus.calc_res, 33'hF);
    chk("busy_err", bus.alu_err, 1'b0);

    // reset while waiting on the multiplier
    mul_lat = 50;
    wait_ready("rst_mid");
    bus.operator = OP_MUL; bus.src1 = 16'h0007; bus.src2 = 16'h0006;
    bus.parser_done = 1'b1;
    @(negedge clk);
    bus.parser_done = 1'b0;
    repeat (5) @(negedge clk);
    n_rst = 1'b0;
    #1;
    check_all_zero("rst_mid");
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_mid_ready_after", bus.ctrl_ready, 1'b1);
    inj_mul_done = 1'b1;
    @(negedge clk);
    inj_mul_done = 1'b0;
    count_done(5, cnt);
    chk("rst_mid_stale_done", 33'(cnt), 33'd0);
    chk("rst_mid_res_zero", bus.calc_res, 33'd0);
    run_op(mk("post_rst_add", 4'h0, OP_ADD, 16'h0100, 16'h0023, 1, 1, 0, 33'h123, 1'b0, 0, 0, 2));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/calc_op_ctrl.md
# calc_op_ctrl

Operation controller for the UART calculator ALU. It accepts one parsed operation from the parser, computes add/sub internally, and sequences the external shift-add multiplier and the divider through a start/done handshake. It returns a single 33-bit result with a one-cycle `alu_done` pulse to the UART response formatter. It sits between the parser and the arithmetic units and is the only block that drives the units' start inputs.

## Interface
- `TIMEOUT_CYC`, default 64: maximum cycles to wait for a unit's done before aborting with error.
- `clk`  in  1  system clock, rising edge.
- `n_rst`  in  1  asynchronous, active-low reset.
- `parser_done`  in  1  operation valid; sampled only while `ctrl_ready`=1.
- `dtype`  in  4  data type; 4'h0 unsigned, 4'h1 signed, others treated as unsigned.
- `operator`  in  5  op code: 0 ADD, 1 SUB, 2 MUL, 3 DIV, 4 MOD, others illegal.
- `src1`, `src2`  in  16 each  operands.
- `ctrl_ready`  out  1  high in IDLE only.
- `mul_start`  out  1  one-cycle start pulse to the multiplier.
- `mul_src1`, `mul_src2`  out  16 each  latched operands, held stable from `mul_start` until done.
- `mul_res`  in  33  multiplier result, valid when `mul_done`=1.
- `mul_done`  in  1  multiplier done.
- `div_start`  out  1  one-cycle start pulse to the divider.
- `div_src1`, `div_src2`  out  16 each  latched operands.
- `div_quot`, `div_rem`  in  16 each  divider outputs, valid with `div_done`.
- `div_done`  in  1  divider done.
- `calc_res`  out  33  result; held until the next `alu_done`.
- `alu_err`  out  1  error flag; valid with `alu_done`, held with `calc_res`.
- `alu_done`  out  1  one-cycle result-valid pulse.

## Operation
- States: IDLE, DISPATCH, WAIT_MUL, WAIT_DIV, DONE.
- **IDLE**, `parser_done`=1: latch dtype, operator, src1, src2 → DISPATCH.
- **DISPATCH**:
  - ADD/SUB: compute into the result register → DONE.
  - MUL: assert `mul_start` → WAIT_MUL.
  - DIV/MOD with src2≠0: assert `div_start` → WAIT_DIV.
  - DIV/MOD with src2=0: result 0, err=1 → DONE; the divider is not started.
  - Illegal operator: result 0, err=1 → DONE.
- **WAIT_MUL / WAIT_DIV**:
  - Done seen: capture the result → DONE.
  - Wait counter reaches `TIMEOUT_CYC` without done: result 0, err=1 → DONE.
  - A done from the non-selected unit is ignored.
- **DONE**: pulse `alu_done` → IDLE.
- Width rules:
  - ADD unsigned: zero-extend to 33, sum.
  - ADD signed: sign-extend both to 33, sum.
  - SUB: same extension rules, src1−src2, 33-bit two's complement.
  - MUL: `mul_res` passed unchanged.
  - DIV: {17'b0, quot}.
  - MOD: {17'b0, rem}.
- `parser_done` outside IDLE is ignored and never queued.
- Reset, including mid-operation: state=IDLE, all outputs 0, wait counter 0. An in-flight unit done arriving after reset is ignored.

## Timing
- `parser_done` sampled at edge N → DISPATCH at N+1.
- ADD/SUB/error: DONE at N+2, `alu_done` high during cycle N+2; total latency 2 cycles.
- MUL/DIV: start pulse during cycle N+1.
- If done is seen at edge M, `alu_done` is high during the cycle after M.
- The wait counter starts at 0 on entry to WAIT and increments every cycle.
- `calc_res`/`alu_err` update on the edge entering DONE, remain stable afterwards.
- `ctrl_ready` goes low the cycle after acceptance and returns high the cycle after `alu_done`.

## Structure
- A shared package `calc_pkg` holds:
  - operator codes (OP_ADD..OP_MOD),
  - dtype codes,
  - state enum,
  - result width constant (33).
- One sub-module is natural: `calc_addsub` (combinational 33-bit add/sub with dtype extension). Everything else is in the FSM.

## Test plan
- MUL unsigned: src1=0x0009, src2=0x0002, stub multiplier returns 33'h12 after 16 cycles → `calc_res`=0x12, `alu_err`=0, exactly one `mul_start` pulse, operands stable throughout.
- ADD unsigned: 0xFFFF+0x0001 → `calc_res`=33'h10000, `alu_done` 2 cycles after `parser_done`.
- SUB:
  - signed 0x0002−0x0009 → 33'h1_FFFF_FFF9.
  - unsigned 0x0009−0x0002 → 0x7.
- DIV/MOD:
  - 9/2 → quot 4, DIV result 0x4, MOD result 0x1.
  - 9/0 → `alu_err`=1, `calc_res`=0, no `div_start`.
- Timeout: MUL with the stub never asserting `mul_done` → `alu_done` with err=1 after `TIMEOUT_CYC` wait cycles. A late `mul_done` afterwards is ignored.
- Robustness:
  - Second `parser_done` while busy is ignored; exactly one `alu_done` per accepted operation.
  - `n_rst` low during WAIT_MUL → all outputs 0, `ctrl_ready`=1 after release.
